cv32e40p_trace_buffer: RTL and testbench
========================================

// Module: cv32e40p_trace_buffer
// PURPOSE
//  Parametrised hardware trace capture for the cv32e40p core: samples NUM_SRC trace taps
//  (e.g. ID-decode, WB-writeback) and stores events (pc, data, source, timestamp) in a DEPTH-entry FIFO.
//  Supports capture modes (all / illegal-only / trigger window) and overwrite-oldest or drop-newest on full.
//  Events drain over a valid/ready port to a debug/log consumer. Sits beside core_i in the core wrapper.
// PARAMETERS
//  NUM_SRC  2   number of trace source channels (>=1)
//  DEPTH    8   FIFO entries, power of 2, >=2
//  TS_W     16  timestamp width
//  SRC_W    (NUM_SRC>1 ? $clog2(NUM_SRC) : 1)  derived, not overridable
// PORTS
//  clk_i          in   1              clock
//  rst_i          in   1              synchronous reset, active-high
//  enable_i       in   1              capture enable
//  flush_i        in   1              clear FIFO and drop counter
//  mode_i         in   2              00 all, 01 illegal-only, 10 trigger window, 11 reserved (=00)
//  wrap_i         in   1              1: overwrite oldest when full; 0: drop new event
//  trigger_i      in   1              window start/stop strobe (mode 10)
//  src_valid_i    in   NUM_SRC        per-source event strobe
//  src_illegal_i  in   NUM_SRC        per-source illegal-instruction flag
//  src_pc_i       in   NUM_SRC*32     per-source PC
//  src_data_i     in   NUM_SRC*32     per-source payload (instr word or rd wdata)
//  out_valid_o    out  1              head entry valid
//  out_ready_i    in   1              consumer accepts head
//  out_src_o      out  SRC_W          head source index
//  out_pc_o       out  32             head PC
//  out_data_o     out  32             head payload
//  out_ts_o       out  TS_W           head timestamp
//  level_o        out  $clog2(DEPTH)+1  entries held
//  drop_cnt_o     out  16             lost events, saturating
//  capturing_o    out  1              FSM in CAPTURE
// BEHAVIOUR
//  Reset: all outputs 0. FSM=IDLE, pointers/level/ts/drop_cnt=0.
//  FSM: IDLE, ARMED, CAPTURE, FROZEN.
//   IDLE  -> CAPTURE if enable_i and mode!=10; -> ARMED if enable_i and mode==10.
//   ARMED -> CAPTURE on trigger_i. The event in the trigger cycle is captured.
//   CAPTURE -> FROZEN on trigger_i (mode 10 only). The event in the stop cycle is captured.
//   any state -> IDLE when enable_i=0. FIFO contents are kept, and draining continues in every state.
//   mode_i/wrap_i may change only while enable_i=0; otherwise behaviour is undefined.
//  Timestamp: free-running TS_W counter. Increments each cycle while enable_i=1 and wraps modulo 2^TS_W.
//   An entry stores the ts value of its capture cycle.
//  Candidate event: src_valid_i[k], and (mode!=01 or src_illegal_i[k]).
//   Only in CAPTURE, or in ARMED during the trigger cycle.
//  Arbitration: lowest-index candidate is written, one write per cycle.
//   Each other candidate increments drop_cnt.
//  Latency: event captured at edge N; out_valid_o=1 after edge N when FIFO was empty. Head is read combinationally from the entry array.
//  Pop: out_valid_o & out_ready_i.
//  Full handling:
//   push & pop same cycle while full: both occur, nothing lost.
//   full, push, no pop, wrap_i=1: oldest entry is overwritten and the head advances; drop_cnt+1; level stays DEPTH.
//    Head may change while out_valid_o=1 & !out_ready_i; this is permitted in wrap mode only.
//   full, push, no pop, wrap_i=0: new event discarded; drop_cnt+1.
//  Empty: out_valid_o=0. out_* fields hold the last value and are don't-care.
//  drop_cnt_o saturates at 16'hFFFF. Multiple drops in one cycle add their count (saturating).
//  flush_i: priority over push/pop. Sets level=0, pointers=0, drop_cnt=0; ts is not cleared.
//   Events in the flush cycle are discarded and not counted.
//   FSM returns to its entry state: IDLE if !enable_i, else ARMED (mode 10) or CAPTURE.
//  Reset mid-capture: same as power-up reset, and the FIFO is emptied.
//  Pointers are log2(DEPTH) bits with wrap-around. level_o = entries held, 0..DEPTH.
// TESTING
//  DEPTH=4,NUM_SRC=2,mode 00: src_valid=2'b11 pc0=0x100,pc1=0x200 one cycle ->
//   out_pc=0x100,out_src=0, level=1, drop_cnt=1.
//  mode 01: 3 events, only 2nd has illegal=1, pc=0x84 -> exactly one entry, pc 0x84.
//  mode 10: events every cycle, trigger at cycles 3 and 6 -> entries from cycles 3..6 only (4 entries).
//   FSM reaches FROZEN; capturing_o=0 afterwards.
//  wrap_i=1, ready=0, 6 events pc=1..6 -> level=4, head pc=3, drop_cnt=2.
//   With wrap_i=0 instead -> head pc=1, tail pc=4, drop_cnt=2.
//  full + push + pop same cycle -> level stays 4, drop_cnt unchanged, order preserved.
//  flush_i coincident with push and pop -> level=0, drop_cnt=0, out_valid=0 next cycle.
//   Then rst_i mid-capture -> all outputs 0.

Source files
------------

// File: rtl/cv32e40p_trace_buffer.sv
// Trace capture FIFO for cv32e40p: samples NUM_SRC trace taps into a DEPTH-entry event buffer
// with all / illegal-only / trigger-window capture and overwrite-or-drop full handling.
module cv32e40p_trace_buffer #(
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned TS_W    = 16,
    localparam int unsigned SRC_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    input  logic                  flush_i,
    input  logic [1:0]            mode_i,
    input  logic                  wrap_i,
    input  logic                  trigger_i,
    input  logic [NUM_SRC-1:0]    src_valid_i,
    input  logic [NUM_SRC-1:0]    src_illegal_i,
    input  logic [NUM_SRC*32-1:0] src_pc_i,
    input  logic [NUM_SRC*32-1:0] src_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [SRC_W-1:0]      out_src_o,
    output logic [31:0]           out_pc_o,
    output logic [31:0]           out_data_o,
    output logic [TS_W-1:0]       out_ts_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic [15:0]           drop_cnt_o,
    output logic                  capturing_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned CNT_W = $clog2(NUM_SRC + 1);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, FROZEN} state_t;

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [TS_W-1:0]    ts;
    logic [SRC_W-1:0]   mem_src  [DEPTH];
    logic [31:0]        mem_pc   [DEPTH];
    logic [31:0]        mem_data [DEPTH];
    logic [TS_W-1:0]    mem_ts   [DEPTH];

    logic               cap_en, push, pop, full, overflow, write;
    logic [NUM_SRC-1:0] cand;
    logic [CNT_W-1:0]   ncand, arb_drops;
    logic [SRC_W-1:0]   sel_src;
    logic [31:0]        sel_pc, sel_data;
    logic [16:0]        drop_sum;

    // Head is presented straight from the entry array.
    assign out_valid_o = (level_o != '0);
    assign out_src_o   = mem_src[rd_ptr];
    assign out_pc_o    = mem_pc[rd_ptr];
    assign out_data_o  = mem_data[rd_ptr];
    assign out_ts_o    = mem_ts[rd_ptr];
    assign capturing_o = (state == CAPTURE);

    always_comb begin
        cap_en    = enable_i && !flush_i &&
                    (state == CAPTURE || (state == ARMED && trigger_i));
        cand      = '0;
        ncand     = '0;
        sel_src   = '0;
        sel_pc    = '0;
        sel_data  = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            cand[k] = cap_en && src_valid_i[k] && (mode_i != 2'b01 || src_illegal_i[k]);
            ncand   = ncand + CNT_W'(cand[k]);
        end
        // Descending scan leaves the lowest-index candidate selected.
        for (int k = int'(NUM_SRC) - 1; k >= 0; k--) begin
            if (cand[k]) begin
                sel_src  = SRC_W'(k);
                sel_pc   = src_pc_i[k*32 +: 32];
                sel_data = src_data_i[k*32 +: 32];
            end
        end
        push      = |cand;
        pop       = out_valid_o && out_ready_i && !flush_i;
        full      = (level_o == LVL_W'(DEPTH));
        overflow  = push && full && !pop;
        write     = push && !(overflow && !wrap_i);
        arb_drops = push ? ncand - CNT_W'(1) : '0;
        drop_sum  = {1'b0, drop_cnt_o} + 17'(arb_drops) + 17'(overflow);

        state_nxt = state;
        if (!enable_i) begin
            state_nxt = IDLE;
        end else if (flush_i) begin
            state_nxt = (mode_i == 2'b10) ? ARMED : CAPTURE;
        end else begin
            case (state)
                IDLE:    state_nxt = (mode_i == 2'b10) ? ARMED : CAPTURE;
                ARMED:   if (trigger_i) state_nxt = CAPTURE;
                CAPTURE: if (trigger_i && mode_i == 2'b10) state_nxt = FROZEN;
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_o    <= '0;
            drop_cnt_o <= '0;
            ts         <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_src[i]  <= '0;
                mem_pc[i]   <= '0;
                mem_data[i] <= '0;
                mem_ts[i]   <= '0;
            end
        end else begin
            state <= state_nxt;
            if (enable_i) ts <= ts + TS_W'(1);
            if (flush_i) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                level_o    <= '0;
                drop_cnt_o <= '0;
            end else begin
                if (write) begin
                    mem_src[wr_ptr]  <= sel_src;
                    mem_pc[wr_ptr]   <= sel_pc;
                    mem_data[wr_ptr] <= sel_data;
                    mem_ts[wr_ptr]   <= ts;
                    wr_ptr           <= wr_ptr + PTR_W'(1);
                end
                // Overwriting in wrap mode consumes the oldest entry.
                if (pop || (overflow && wrap_i)) rd_ptr <= rd_ptr + PTR_W'(1);
                if (write && !pop && !full)      level_o <= level_o + LVL_W'(1);
                else if (pop && !write)          level_o <= level_o - LVL_W'(1);
                drop_cnt_o <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            end
        end
    end

endmodule

// File: tb/tb_cv32e40p_trace_buffer.sv
// Directed self-checking bench for cv32e40p_trace_buffer (DEPTH=4, NUM_SRC=2).
module tb_cv32e40p_trace_buffer;

    localparam int unsigned NUM_SRC = 2;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TS_W    = 16;

    logic                  clk = 1'b0;
    logic                  rst_i = 1'b1;
    logic                  enable_i = 1'b0;
    logic                  flush_i = 1'b0;
    logic [1:0]            mode_i = 2'b00;
    logic                  wrap_i = 1'b0;
    logic                  trigger_i = 1'b0;
    logic [NUM_SRC-1:0]    src_valid_i = '0;
    logic [NUM_SRC-1:0]    src_illegal_i = '0;
    logic [NUM_SRC*32-1:0] src_pc_i = '0;
    logic [NUM_SRC*32-1:0] src_data_i = '0;
    logic                  out_valid_o;
    logic                  out_ready_i = 1'b0;
    logic [0:0]            out_src_o;
    logic [31:0]           out_pc_o;
    logic [31:0]           out_data_o;
    logic [TS_W-1:0]       out_ts_o;
    logic [2:0]            level_o;
    logic [15:0]           drop_cnt_o;
    logic                  capturing_o;

    int errors = 0;
    int checks = 0;

    cv32e40p_trace_buffer #(.NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .flush_i(flush_i),
        .mode_i(mode_i), .wrap_i(wrap_i), .trigger_i(trigger_i),
        .src_valid_i(src_valid_i), .src_illegal_i(src_illegal_i),
        .src_pc_i(src_pc_i), .src_data_i(src_data_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_src_o(out_src_o),
        .out_pc_o(out_pc_o), .out_data_o(out_data_o), .out_ts_o(out_ts_o),
        .level_o(level_o), .drop_cnt_o(drop_cnt_o), .capturing_o(capturing_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Disable, set mode/wrap, flush, then re-enable for one cycle.
    task automatic restart(input logic [1:0] m, input logic w);
        enable_i = 1'b0; src_valid_i = '0; trigger_i = 1'b0; out_ready_i = 1'b0;
        step();
        mode_i = m; wrap_i = w; flush_i = 1'b1;
        step();
        flush_i = 1'b0; enable_i = 1'b1;
        step();
    endtask

    task automatic ev(input logic [31:0] pc, input logic ill);
        src_valid_i = 2'b01; src_illegal_i = {1'b0, ill};
        src_pc_i[31:0] = pc; src_data_i[31:0] = ~pc;
        step();
        src_valid_i = '0; src_illegal_i = '0;
    endtask

    task automatic drain(input string tag, input int first, input int n);
        out_ready_i = 1'b1;
        for (int i = 0; i < n; i++) begin
            check({tag, "_order"}, out_pc_o, 32'(first + i));
            step();
        end
        out_ready_i = 1'b0;
        check({tag, "_empty"}, 32'(out_valid_o), 32'd0);
    endtask

    initial begin
        // Reset
        step(); step();
        check("rst_valid", 32'(out_valid_o), 0);
        check("rst_level", 32'(level_o), 0);
        check("rst_drop", 32'(drop_cnt_o), 0);
        check("rst_cap", 32'(capturing_o), 0);
        check("rst_pc", out_pc_o, 0);
        rst_i = 1'b0;

        // Mode 00: two sources at once, lowest index wins
        enable_i = 1'b1;
        step();
        src_valid_i = 2'b11;
        src_pc_i = {32'h200, 32'h100};
        src_data_i = {32'hD1, 32'hD0};
        step();
        src_valid_i = '0;
        check("m0_valid", 32'(out_valid_o), 1);
        check("m0_pc", out_pc_o, 32'h100);
        check("m0_src", 32'(out_src_o), 0);
        check("m0_data", out_data_o, 32'hD0);
        check("m0_ts", 32'(out_ts_o), 1);
        check("m0_level", 32'(level_o), 1);
        check("m0_drop", 32'(drop_cnt_o), 1);
        check("m0_cap", 32'(capturing_o), 1);
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
        check("m0_pop_level", 32'(level_o), 0);

        // Mode 01: illegal-only
        restart(2'b01, 1'b0);
        ev(32'h80, 1'b0); ev(32'h84, 1'b1); ev(32'h88, 1'b0);
        check("m1_level", 32'(level_o), 1);
        check("m1_pc", out_pc_o, 32'h84);
        check("m1_data", out_data_o, 32'hFFFF_FF7B);
        check("m1_drop", 32'(drop_cnt_o), 0);

        // Mode 10: trigger window cycles 3..6
        restart(2'b10, 1'b0);
        check("m2_armed_cap", 32'(capturing_o), 0);
        for (int c = 1; c <= 8; c++) begin
            src_valid_i = 2'b01; src_pc_i[31:0] = 32'(c);
            trigger_i = (c == 3 || c == 6);
            step();
        end
        src_valid_i = '0; trigger_i = 1'b0;
        check("m2_frozen_cap", 32'(capturing_o), 0);
        check("m2_level", 32'(level_o), 4);
        check("m2_drop", 32'(drop_cnt_o), 0);
        drain("m2", 3, 4);

        // Full with wrap: oldest overwritten
        restart(2'b00, 1'b1);
        for (int i = 1; i <= 6; i++) ev(32'(i), 1'b0);
        check("wrap_level", 32'(level_o), 4);
        check("wrap_drop", 32'(drop_cnt_o), 2);
        drain("wrap", 3, 4);

        // Full without wrap: newest dropped
        restart(2'b00, 1'b0);
        for (int i = 1; i <= 6; i++) ev(32'(i), 1'b0);
        check("nowrap_level", 32'(level_o), 4);
        check("nowrap_drop", 32'(drop_cnt_o), 2);
        drain("nowrap", 1, 4);

        // Full with simultaneous push and pop
        restart(2'b00, 1'b0);
        for (int i = 1; i <= 4; i++) ev(32'(i), 1'b0);
        check("pp_full", 32'(level_o), 4);
        src_valid_i = 2'b01; src_pc_i[31:0] = 32'd5; out_ready_i = 1'b1;
        step();
        src_valid_i = '0; out_ready_i = 1'b0;
        check("pp_level", 32'(level_o), 4);
        check("pp_drop", 32'(drop_cnt_o), 0);
        drain("pp", 2, 4);

        // Flush coincident with push and pop
        restart(2'b00, 1'b0);
        src_valid_i = 2'b11; src_pc_i = {32'd99, 32'd1};
        step();
        ev(32'd2, 1'b0);
        check("fl_pre_level", 32'(level_o), 2);
        check("fl_pre_drop", 32'(drop_cnt_o), 1);
        flush_i = 1'b1; src_valid_i = 2'b01; out_ready_i = 1'b1;
        step();
        flush_i = 1'b0; src_valid_i = '0; out_ready_i = 1'b0;
        check("fl_level", 32'(level_o), 0);
        check("fl_drop", 32'(drop_cnt_o), 0);
        check("fl_valid", 32'(out_valid_o), 0);
        check("fl_cap", 32'(capturing_o), 1);

        // Reset mid-capture
        ev(32'd7, 1'b0);
        check("mid_level", 32'(level_o), 1);
        rst_i = 1'b1;
        step();
        check("rst2_valid", 32'(out_valid_o), 0);
        check("rst2_level", 32'(level_o), 0);
        check("rst2_cap", 32'(capturing_o), 0);
        check("rst2_pc", out_pc_o, 0);
        check("rst2_ts", 32'(out_ts_o), 0);
        rst_i = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
